ex_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS32 pipeline. Consumes the ID/EX register outputs and computes the ALU result.

---
 rtl/ex_stage_pkg.sv | 87 ++++++++
 rtl/ex_stage_div_iter.sv | 141 ++++++++++++++
 rtl/ex_stage.sv | 195 +++++++++++++++++++
 tb/tb_ex_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the MIPS32 execute stage: bus widths, ALU operation
// codes, result-class selectors, divider state encoding and a small helper.
package ex_stage_pkg;

    // Reset level and datapath widths
    localparam logic RST_ENABLE          = 1'b1;
    localparam int   REG_W               = 32;
    localparam int   REG_ADDR_W          = 5;
    localparam int   DOUBLE_REG_W        = 64;
    localparam int   DIV_CYCLES_DEFAULT  = 32;

    // ALU operation codes as decoded by the ID stage
    localparam logic [7:0] ALU_NOP   = 8'b0000_0000;
    localparam logic [7:0] ALU_AND   = 8'b0010_0100;
    localparam logic [7:0] ALU_OR    = 8'b0010_0101;
    localparam logic [7:0] ALU_XOR   = 8'b0010_0110;
    localparam logic [7:0] ALU_NOR   = 8'b0010_0111;
    localparam logic [7:0] ALU_SLL   = 8'b0111_1100;
    localparam logic [7:0] ALU_SRL   = 8'b0000_0010;
    localparam logic [7:0] ALU_SRA   = 8'b0000_0011;
    localparam logic [7:0] ALU_MOVZ  = 8'b0000_1010;
    localparam logic [7:0] ALU_MOVN  = 8'b0000_1011;
    localparam logic [7:0] ALU_MFHI  = 8'b0001_0000;
    localparam logic [7:0] ALU_MTHI  = 8'b0001_0001;
    localparam logic [7:0] ALU_MFLO  = 8'b0001_0010;
    localparam logic [7:0] ALU_MTLO  = 8'b0001_0011;
    localparam logic [7:0] ALU_SLT   = 8'b0010_1010;
    localparam logic [7:0] ALU_SLTU  = 8'b0010_1011;
    localparam logic [7:0] ALU_ADD   = 8'b0010_0000;
    localparam logic [7:0] ALU_ADDU  = 8'b0010_0001;
    localparam logic [7:0] ALU_SUB   = 8'b0010_0010;
    localparam logic [7:0] ALU_SUBU  = 8'b0010_0011;
    localparam logic [7:0] ALU_ADDI  = 8'b0101_0101;
    localparam logic [7:0] ALU_ADDIU = 8'b0101_0110;
    localparam logic [7:0] ALU_CLZ   = 8'b1011_0000;
    localparam logic [7:0] ALU_CLO   = 8'b1011_0001;
    localparam logic [7:0] ALU_MULT  = 8'b0001_1000;
    localparam logic [7:0] ALU_MULTU = 8'b0001_1001;
    localparam logic [7:0] ALU_MUL   = 8'b1010_1001;
    localparam logic [7:0] ALU_DIV   = 8'b0001_1010;
    localparam logic [7:0] ALU_DIVU  = 8'b0001_1011;
    localparam logic [7:0] ALU_JAL   = 8'b0101_0000;

    // Result class selectors
    localparam logic [2:0] SEL_NOP         = 3'b000;
    localparam logic [2:0] SEL_LOGIC       = 3'b001;
    localparam logic [2:0] SEL_SHIFT       = 3'b010;
    localparam logic [2:0] SEL_MOVE        = 3'b011;
    localparam logic [2:0] SEL_ARITH       = 3'b100;
    localparam logic [2:0] SEL_MUL         = 3'b101;
    localparam logic [2:0] SEL_JUMP_BRANCH = 3'b110;

    // Divider control states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_BUSY = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

    // Number of zero bits above the most significant one; 32 for an all-zero word
    function automatic logic [5:0] count_leading_zeros(input logic [REG_W-1:0] value);
        logic [5:0] count;
        logic       found;
        count = 6'd0;
        found = 1'b0;
        for (int i = REG_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (value[i]) begin
                    found = 1'b1;
                end else begin
                    count = count + 6'd1;
                end
            end
        end
        return count;
    endfunction

    // Two's-complement magnitude when the operand is treated as signed
    function automatic logic [REG_W-1:0] magnitude(input logic is_signed, input logic [REG_W-1:0] value);
        if (is_signed && value[REG_W-1]) begin
            return ~value + 1'b1;
        end
        return value;
    endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, with sign fix-up applied as the result is registered.
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_i,
    input  logic [REG_W-1:0]        opdata1_i,
    input  logic [REG_W-1:0]        opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DOUBLE_REG_W-1:0] result_o,
    output logic                    ready_o
);

    localparam int               CNT_W     = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

    div_state_e                state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [REG_W-1:0]          rem_q, rem_d;
    logic [REG_W-1:0]          quot_q, quot_d;
    logic [REG_W-1:0]          divisor_q, divisor_d;
    logic                      neg_quot_q, neg_quot_d;
    logic                      neg_rem_q, neg_rem_d;
    logic [DOUBLE_REG_W-1:0]   result_q, result_d;
    logic                      ready_q, ready_d;

    logic [REG_W:0]            partial;
    logic [REG_W:0]            trial;
    logic [REG_W-1:0]          rem_step;
    logic [REG_W-1:0]          quot_step;
    logic [REG_W-1:0]          quot_signed;
    logic [REG_W-1:0]          rem_signed;

    // One restoring step: shift the next dividend bit in, subtract if it fits
    always_comb begin
        partial = {rem_q, quot_q[REG_W-1]};
        trial   = partial - {1'b0, divisor_q};
        if (trial[REG_W]) begin
            rem_step  = partial[REG_W-1:0];
            quot_step = {quot_q[REG_W-2:0], 1'b0};
        end else begin
            rem_step  = trial[REG_W-1:0];
            quot_step = {quot_q[REG_W-2:0], 1'b1};
        end
        quot_signed = neg_quot_q ? (~quot_step + 1'b1) : quot_step;
        rem_signed  = neg_rem_q  ? (~rem_step  + 1'b1) : rem_step;
    end

    // Next-state and next-output logic for the divider FSM
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    count_d    = '0;
                    rem_d      = '0;
                    quot_d     = magnitude(signed_i, opdata1_i);
                    divisor_d  = magnitude(signed_i, opdata2_i);
                    neg_quot_d = signed_i & (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
                    neg_rem_d  = signed_i & opdata1_i[REG_W-1];
                    state_d    = (opdata2_i == '0) ? DIV_ZERO : DIV_BUSY;
                end
            end
            DIV_ZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = DIV_DONE;
            end
            DIV_BUSY: begin
                rem_d   = rem_step;
                quot_d  = quot_step;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    result_d = {rem_signed, quot_signed};
                    ready_d  = 1'b1;
                    state_d  = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (start_i) begin
                    ready_d = 1'b1;
                end else begin
                    result_d = '0;
                    state_d  = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        if (annul_i) begin
            state_d  = DIV_IDLE;
            ready_d  = 1'b0;
            result_d = '0;
        end
    end

    // Divider state and registered outputs
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q    <= DIV_IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS32 pipeline: ALU, HI/LO forwarding,
// multiplies, and an iterative divider that stalls the pipeline while busy.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            aluop_i,
    input  logic [2:0]            alusel_i,
    input  logic [REG_W-1:0]      reg1_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      link_address_i,
    input  logic                  is_in_delayslot_i,
    input  logic [REG_W-1:0]      hi_i,
    input  logic [REG_W-1:0]      lo_i,
    input  logic                  mem_whilo_i,
    input  logic [REG_W-1:0]      mem_hi_i,
    input  logic [REG_W-1:0]      mem_lo_i,
    input  logic                  wb_whilo_i,
    input  logic [REG_W-1:0]      wb_hi_i,
    input  logic [REG_W-1:0]      wb_lo_i,
    input  logic                  annul_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  whilo_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  stallreq_o
);

    logic [REG_W-1:0]        hi_fwd, lo_fwd;
    logic [REG_W-1:0]        logic_res, shift_res, move_res, arith_res;
    logic [REG_W-1:0]        sum, diff;
    logic                    ov_add, ov_sub, overflow_trap;
    logic [DOUBLE_REG_W-1:0] mul_s, mul_u;
    logic                    is_div, div_start, div_ready;
    logic [DOUBLE_REG_W-1:0] div_result;
    logic                    unused_delayslot;

    // The delay-slot flag is carried for later exception handling only
    assign unused_delayslot = is_in_delayslot_i;

    assign is_div    = (aluop_i == ALU_DIV) || (aluop_i == ALU_DIVU);
    assign div_start = is_div & ~div_ready & ~annul_i;

    // Newest HI/LO wins: MEM-stage write, then WB-stage write, then architectural
    always_comb begin
        if (mem_whilo_i) begin
            hi_fwd = mem_hi_i;
            lo_fwd = mem_lo_i;
        end else if (wb_whilo_i) begin
            hi_fwd = wb_hi_i;
            lo_fwd = wb_lo_i;
        end else begin
            hi_fwd = hi_i;
            lo_fwd = lo_i;
        end
    end

    // Bitwise logic results
    always_comb begin
        case (aluop_i)
            ALU_AND: logic_res = reg1_i & reg2_i;
            ALU_OR:  logic_res = reg1_i | reg2_i;
            ALU_XOR: logic_res = reg1_i ^ reg2_i;
            ALU_NOR: logic_res = ~(reg1_i | reg2_i);
            default: logic_res = '0;
        endcase
    end

    // Shifts of rt by the amount held in the low five bits of rs
    always_comb begin
        case (aluop_i)
            ALU_SLL: shift_res = reg2_i << reg1_i[4:0];
            ALU_SRL: shift_res = reg2_i >> reg1_i[4:0];
            ALU_SRA: shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            default: shift_res = '0;
        endcase
    end

    // Register moves, including reads of the forwarded HI/LO
    always_comb begin
        case (aluop_i)
            ALU_MFHI: move_res = hi_fwd;
            ALU_MFLO: move_res = lo_fwd;
            ALU_MOVZ: move_res = reg1_i;
            ALU_MOVN: move_res = reg1_i;
            default:  move_res = '0;
        endcase
    end

    // Add/subtract with signed-overflow detection, compares and bit counts
    always_comb begin
        sum    = reg1_i + reg2_i;
        diff   = reg1_i - reg2_i;
        ov_add = (reg1_i[REG_W-1] == reg2_i[REG_W-1]) && (sum[REG_W-1]  != reg1_i[REG_W-1]);
        ov_sub = (reg1_i[REG_W-1] != reg2_i[REG_W-1]) && (diff[REG_W-1] != reg1_i[REG_W-1]);
        case (aluop_i)
            ALU_ADD, ALU_ADDU, ALU_ADDI, ALU_ADDIU: arith_res = sum;
            ALU_SUB, ALU_SUBU:                     arith_res = diff;
            ALU_SLT:  arith_res = {{(REG_W-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
            ALU_SLTU: arith_res = {{(REG_W-1){1'b0}}, reg1_i < reg2_i};
            ALU_CLZ:  arith_res = {{(REG_W-6){1'b0}}, count_leading_zeros(reg1_i)};
            ALU_CLO:  arith_res = {{(REG_W-6){1'b0}}, count_leading_zeros(~reg1_i)};
            default:  arith_res = '0;
        endcase
    end

    // Full 64-bit products for the signed and unsigned multiplies
    always_comb begin
        mul_s = $unsigned($signed({{REG_W{reg1_i[REG_W-1]}}, reg1_i}) *
                          $signed({{REG_W{reg2_i[REG_W-1]}}, reg2_i}));
        mul_u = {{REG_W{1'b0}}, reg1_i} * {{REG_W{1'b0}}, reg2_i};
    end

    // Trapping adds and subtracts drop their register write on overflow
    assign overflow_trap = (((aluop_i == ALU_ADD) || (aluop_i == ALU_ADDI)) && ov_add) ||
                           ((aluop_i == ALU_SUB) && ov_sub);

    div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .signed_i  (aluop_i == ALU_DIV),
        .opdata1_i (reg1_i),
        .opdata2_i (reg2_i),
        .start_i   (div_start),
        .annul_i   (annul_i),
        .result_o  (div_result),
        .ready_o   (div_ready)
    );

    // Final result selection; everything is held at zero during reset
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i & ~overflow_trap;
            stallreq_o = is_div & ~div_ready;

            case (alusel_i)
                SEL_LOGIC:       wdata_o = logic_res;
                SEL_SHIFT:       wdata_o = shift_res;
                SEL_MOVE:        wdata_o = move_res;
                SEL_ARITH:       wdata_o = arith_res;
                SEL_MUL:         wdata_o = (aluop_i == ALU_MUL) ? mul_s[REG_W-1:0] : '0;
                SEL_JUMP_BRANCH: wdata_o = link_address_i;
                default:         wdata_o = '0;
            endcase

            case (aluop_i)
                ALU_MTHI: begin
                    whilo_o = 1'b1;
                    hi_o    = reg1_i;
                    lo_o    = lo_fwd;
                end
                ALU_MTLO: begin
                    whilo_o = 1'b1;
                    hi_o    = hi_fwd;
                    lo_o    = reg1_i;
                end
                ALU_MULT: begin
                    whilo_o = 1'b1;
                    {hi_o, lo_o} = mul_s;
                end
                ALU_MULTU: begin
                    whilo_o = 1'b1;
                    {hi_o, lo_o} = mul_u;
                end
                ALU_DIV, ALU_DIVU: begin
                    if (div_ready) begin
                        whilo_o = 1'b1;
                        {hi_o, lo_o} = div_result;
                    end
                end
                default: begin
                    whilo_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized ALU
// and divide traffic compared against an arithmetic reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] link_address_i;
    logic        is_in_delayslot_i;
    logic [31:0] hi_i, lo_i;
    logic        mem_whilo_i;
    logic [31:0] mem_hi_i, mem_lo_i;
    logic        wb_whilo_i;
    logic [31:0] wb_hi_i, wb_lo_i;
    logic        annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;

    int checkCount = 0;
    int passCount  = 0;

    localparam int NUM_OPS = 29;

    ex_stage dut (
        .clk               (clk),
        .rst               (rst),
        .aluop_i           (aluop_i),
        .alusel_i          (alusel_i),
        .reg1_i            (reg1_i),
        .reg2_i            (reg2_i),
        .wd_i              (wd_i),
        .wreg_i            (wreg_i),
        .link_address_i    (link_address_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .hi_i              (hi_i),
        .lo_i              (lo_i),
        .mem_whilo_i       (mem_whilo_i),
        .mem_hi_i          (mem_hi_i),
        .mem_lo_i          (mem_lo_i),
        .wb_whilo_i        (wb_whilo_i),
        .wb_hi_i           (wb_hi_i),
        .wb_lo_i           (wb_lo_i),
        .annul_i           (annul_i),
        .wd_o              (wd_o),
        .wreg_o            (wreg_o),
        .wdata_o           (wdata_o),
        .whilo_o           (whilo_o),
        .hi_o              (hi_o),
        .lo_o              (lo_o),
        .stallreq_o        (stallreq_o)
    );

    // Free-running pipeline clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one instruction on the ID/EX side
    task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] a, input logic [31:0] b);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] opAt(input int idx);
        case (idx)
            0:  return ALU_AND;   1:  return ALU_OR;    2:  return ALU_XOR;
            3:  return ALU_NOR;   4:  return ALU_SLL;   5:  return ALU_SRL;
            6:  return ALU_SRA;   7:  return ALU_MOVZ;  8:  return ALU_MOVN;
            9:  return ALU_MFHI;  10: return ALU_MFLO;  11: return ALU_MTHI;
            12: return ALU_MTLO;  13: return ALU_SLT;   14: return ALU_SLTU;
            15: return ALU_ADD;   16: return ALU_ADDU;  17: return ALU_SUB;
            18: return ALU_SUBU;  19: return ALU_ADDI;  20: return ALU_ADDIU;
            21: return ALU_CLZ;   22: return ALU_CLO;   23: return ALU_MUL;
            24: return ALU_MULT;  25: return ALU_MULTU; 26: return ALU_JAL;
            27: return ALU_NOP;
            default: return 8'hEE;
        endcase
    endfunction

    function automatic logic [2:0] selFor(input logic [7:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOR:                   return SEL_LOGIC;
            ALU_SLL, ALU_SRL, ALU_SRA:                           return SEL_SHIFT;
            ALU_MOVZ, ALU_MOVN, ALU_MFHI, ALU_MFLO:              return SEL_MOVE;
            ALU_MUL:                                             return SEL_MUL;
            ALU_JAL:                                             return SEL_JUMP_BRANCH;
            ALU_NOP, ALU_MTHI, ALU_MTLO, ALU_MULT, ALU_MULTU:    return SEL_NOP;
            8'hEE:                                               return SEL_LOGIC;
            default:                                             return SEL_ARITH;
        endcase
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001 << $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    // Reference model of the non-divide instructions, from the ISA definitions
    task automatic refModel(input logic [7:0] op, input logic [2:0] sel,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] link,
                            input logic [31:0] hiF, input logic [31:0] loF, input logic wrIn,
                            output logic [31:0] wdata, output logic wreg, output logic whilo,
                            output logic [31:0] hi, output logic [31:0] lo);
        longint     wide;
        logic [63:0] prod;
        int         cnt;
        logic [31:0] scan;
        wdata = 32'd0;
        wreg  = wrIn;
        whilo = 1'b0;
        hi    = 32'd0;
        lo    = 32'd0;
        case (op)
            ALU_AND:  wdata = a & b;
            ALU_OR:   wdata = a | b;
            ALU_XOR:  wdata = a ^ b;
            ALU_NOR:  wdata = ~(a | b);
            ALU_SLL:  wdata = b << a[4:0];
            ALU_SRL:  wdata = b >> a[4:0];
            ALU_SRA:  wdata = $unsigned($signed(b) >>> a[4:0]);
            ALU_MOVZ, ALU_MOVN: wdata = a;
            ALU_MFHI: wdata = hiF;
            ALU_MFLO: wdata = loF;
            ALU_MTHI: begin whilo = 1'b1; hi = a; lo = loF; end
            ALU_MTLO: begin whilo = 1'b1; hi = hiF; lo = a; end
            ALU_SLT:  wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: wdata = (a < b) ? 32'd1 : 32'd0;
            ALU_ADD, ALU_ADDI, ALU_ADDU, ALU_ADDIU: begin
                wide  = longint'($signed(a)) + longint'($signed(b));
                wdata = a + b;
                if ((op == ALU_ADD || op == ALU_ADDI) &&
                    (wide > 64'sd2147483647 || wide < -64'sd2147483648)) wreg = 1'b0;
            end
            ALU_SUB, ALU_SUBU: begin
                wide  = longint'($signed(a)) - longint'($signed(b));
                wdata = a - b;
                if (op == ALU_SUB && (wide > 64'sd2147483647 || wide < -64'sd2147483648)) wreg = 1'b0;
            end
            ALU_CLZ, ALU_CLO: begin
                scan = (op == ALU_CLO) ? ~a : a;
                cnt  = 32;
                for (int i = 31; i >= 0; i--) begin
                    if (scan[i]) begin
                        cnt = 31 - i;
                        break;
                    end
                end
                wdata = 32'(cnt);
            end
            ALU_MUL: begin
                wide  = longint'($signed(a)) * longint'($signed(b));
                wdata = wide[31:0];
            end
            ALU_MULT: begin
                wide  = longint'($signed(a)) * longint'($signed(b));
                whilo = 1'b1;
                hi    = wide[63:32];
                lo    = wide[31:0];
            end
            ALU_MULTU: begin
                prod  = {32'd0, a} * {32'd0, b};
                whilo = 1'b1;
                hi    = prod[63:32];
                lo    = prod[31:0];
            end
            default: wdata = 32'd0;
        endcase
        if (sel == SEL_JUMP_BRANCH) wdata = link;
    endtask

    // Issue one divide and hold it until the stage stops stalling
    task automatic runDivide(input string tag, input logic isSigned, input logic [31:0] a, input logic [31:0] b);
        int         qs, rs;
        logic [31:0] expQ, expR;
        int         stallCycles;
        logic       finished;
        logic       earlyWhilo;
        if (b == 32'd0) begin
            expQ = 32'd0;
            expR = 32'd0;
        end else if (isSigned) begin
            qs   = $signed(a) / $signed(b);
            rs   = $signed(a) % $signed(b);
            expQ = qs;
            expR = rs;
        end else begin
            expQ = a / b;
            expR = a % b;
        end
        applyStimulus(isSigned ? ALU_DIV : ALU_DIVU, SEL_NOP, a, b);
        stallCycles = 0;
        finished    = 1'b0;
        earlyWhilo  = 1'b0;
        for (int c = 0; c < 100 && !finished; c++) begin
            @(negedge clk);
            if (stallreq_o) begin
                stallCycles++;
                if (whilo_o) earlyWhilo = 1'b1;
                nextCycle();
            end else begin
                finished = 1'b1;
                checkOutput({tag, "_whilo"}, 64'(whilo_o), 64'd1);
                checkOutput({tag, "_lo"}, 64'(lo_o), 64'(expQ));
                checkOutput({tag, "_hi"}, 64'(hi_o), 64'(expR));
                checkOutput({tag, "_early_whilo"}, 64'(earlyWhilo), 64'd0);
                if (b != 32'd0) checkOutput({tag, "_stall_cycles"}, 64'(stallCycles), 64'd33);
            end
        end
        if (!finished) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        nextCycle();
    endtask

    // Start a signed divide and flush it partway through the iterations
    task automatic runAnnul(input logic [31:0] a, input logic [31:0] b, input int annulCycle);
        applyStimulus(ALU_DIV, SEL_NOP, a, b);
        repeat (annulCycle) nextCycle();
        annul_i = 1'b1;
        @(negedge clk);
        checkOutput("annul_whilo", 64'(whilo_o), 64'd0);
        nextCycle();
        annul_i = 1'b0;
    endtask

    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a, b, expWdata, expHi, expLo, hiF, loF;
    logic        expWreg, expWhilo;

    initial begin
        rst = 1'b1;
        applyStimulus(ALU_ADD, SEL_ARITH, 32'h1234_5678, 32'h0000_1111);
        wd_i = 5'd9; wreg_i = 1'b1; link_address_i = 32'h0040_0008; is_in_delayslot_i = 1'b0;
        hi_i = 32'hAAAA_0001; lo_i = 32'hBBBB_0001;
        mem_whilo_i = 1'b0; mem_hi_i = '0; mem_lo_i = '0;
        wb_whilo_i = 1'b0; wb_hi_i = '0; wb_lo_i = '0;
        annul_i = 1'b0;
        nextCycle();
        nextCycle();

        // Outputs held at zero while reset is asserted
        @(negedge clk);
        checkOutput("reset_wdata", 64'(wdata_o), 64'd0);
        checkOutput("reset_wreg", 64'(wreg_o), 64'd0);
        checkOutput("reset_wd", 64'(wd_o), 64'd0);
        applyStimulus(ALU_MULT, SEL_NOP, 32'd5, 32'd6);
        #1;
        checkOutput("reset_whilo", 64'(whilo_o), 64'd0);
        applyStimulus(ALU_DIV, SEL_NOP, 32'd5, 32'd6);
        #1;
        checkOutput("reset_stall", 64'(stallreq_o), 64'd0);
        nextCycle();
        rst = 1'b0;

        // Signed add overflow suppresses the write, unsigned add does not
        applyStimulus(ALU_ADD, SEL_ARITH, 32'h7FFF_FFFF, 32'd1);
        @(negedge clk);
        checkOutput("add_ovf_wreg", 64'(wreg_o), 64'd0);
        checkOutput("add_wd", 64'(wd_o), 64'd9);
        nextCycle();
        applyStimulus(ALU_ADDU, SEL_ARITH, 32'h7FFF_FFFF, 32'd1);
        @(negedge clk);
        checkOutput("addu_wdata", 64'(wdata_o), 64'h8000_0000);
        checkOutput("addu_wreg", 64'(wreg_o), 64'd1);
        nextCycle();

        // HI forwarding priority
        hi_i = 32'd1; wb_hi_i = 32'd2; mem_hi_i = 32'd3;
        mem_whilo_i = 1'b1; wb_whilo_i = 1'b1;
        applyStimulus(ALU_MFHI, SEL_MOVE, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("mfhi_mem", 64'(wdata_o), 64'd3);
        mem_whilo_i = 1'b0;
        #1;
        checkOutput("mfhi_wb", 64'(wdata_o), 64'd2);
        wb_whilo_i = 1'b0;
        #1;
        checkOutput("mfhi_arch", 64'(wdata_o), 64'd1);
        nextCycle();

        // Signed 64-bit multiply
        applyStimulus(ALU_MULT, SEL_NOP, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        checkOutput("mult_whilo", 64'(whilo_o), 64'd1);
        checkOutput("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        checkOutput("mult_lo", 64'(lo_o), 64'hFFFF_FFFE);
        nextCycle();

        // Divides, including divide by zero and a flushed divide
        runDivide("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        runDivide("divu_7_0", 1'b0, 32'd7, 32'd0);
        runAnnul(32'd12345, 32'd17, 10);
        runDivide("divu_100_7", 1'b0, 32'd100, 32'd7);

        // Reset in the middle of a divide
        applyStimulus(ALU_DIV, SEL_NOP, 32'd1000, 32'd3);
        repeat (5) nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_stall", 64'(stallreq_o), 64'd0);
        checkOutput("midrst_whilo", 64'(whilo_o), 64'd0);
        checkOutput("midrst_wdata", 64'(wdata_o), 64'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(ALU_CLZ, SEL_ARITH, 32'h0001_0000, 32'd0);
        @(negedge clk);
        checkOutput("clz_wdata", 64'(wdata_o), 64'd15);
        checkOutput("clz_stall", 64'(stallreq_o), 64'd0);
        nextCycle();
        runDivide("div_after_rst", 1'b1, 32'hFFFF_FC18, 32'd3);

        // Back-to-back randomized divides
        for (int n = 0; n < 6; n++) begin
            a = randOperand();
            b = (n == 3) ? 32'd0 : randOperand();
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd7;
            runDivide($sformatf("rand_div%0d", n), 1'($urandom_range(0, 1)), a, b);
        end

        // Randomized single-cycle ALU traffic with random forwarding state
        for (int n = 0; n < 300; n++) begin
            op  = opAt($urandom_range(0, NUM_OPS - 1));
            sel = selFor(op);
            a   = randOperand();
            b   = randOperand();
            wd_i = 5'($urandom);
            wreg_i = 1'($urandom);
            link_address_i = $urandom;
            is_in_delayslot_i = 1'($urandom);
            hi_i = $urandom; lo_i = $urandom;
            mem_whilo_i = 1'($urandom); mem_hi_i = $urandom; mem_lo_i = $urandom;
            wb_whilo_i = 1'($urandom);  wb_hi_i = $urandom;  wb_lo_i = $urandom;
            applyStimulus(op, sel, a, b);
            @(negedge clk);
            hiF = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
            loF = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
            refModel(op, sel, a, b, link_address_i, hiF, loF, wreg_i,
                     expWdata, expWreg, expWhilo, expHi, expLo);
            checkOutput($sformatf("rand_wdata_op%02h", op), 64'(wdata_o), 64'(expWdata));
            checkOutput($sformatf("rand_wreg_op%02h", op), 64'(wreg_o), 64'(expWreg));
            checkOutput($sformatf("rand_wd_op%02h", op), 64'(wd_o), 64'(wd_i));
            checkOutput($sformatf("rand_whilo_op%02h", op), 64'(whilo_o), 64'(expWhilo));
            checkOutput($sformatf("rand_stall_op%02h", op), 64'(stallreq_o), 64'd0);
            if (expWhilo) begin
                checkOutput($sformatf("rand_hi_op%02h", op), 64'(hi_o), 64'(expHi));
                checkOutput($sformatf("rand_lo_op%02h", op), 64'(lo_o), 64'(expLo));
            end
            nextCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
